// File: rtl/debug_step_if.sv
// Command/dump handshake and run-control status bundle between the UART side
// and the debug run-control block.
interface debug_step_if #(
    parameter int CNT_W = 32
) ();
    logic [7:0]       rx_data;
    logic             rx_done_tick;
    logic             dump_done;
    logic             pipe_en;
    logic             dump_start;
    logic [1:0]       mode;
    logic             cmd_error;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output rx_data, rx_done_tick, dump_done,
        input  pipe_en, dump_start, mode, cmd_error, cycle_count
    );

    modport slave (
        input  rx_data, rx_done_tick, dump_done,
        output pipe_en, dump_start, mode, cmd_error, cycle_count
    );
endinterface

// File: rtl/debug_step_ctrl.sv
// Debug run-control: decodes UART command bytes into free-run / halt / N-step
// pipeline enable, requests register dumps and counts enabled cycles.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   S_HALT      | pipeline stopped, waiting for a command
//   S_ARG       | 'n' received, next byte is the step count (0 = 256)
//   S_RUN       | free-running, pipe_en=1
//   S_STEP      | stepping, step_rem cycles left including this one
//   S_DUMP_WAIT | dump requested, waiting for dump_done
module debug_step_ctrl #(
    parameter logic [7:0] CMD_RUN   = 8'h63,
    parameter logic [7:0] CMD_HALT  = 8'h68,
    parameter logic [7:0] CMD_STEP  = 8'h73,
    parameter logic [7:0] CMD_STEPN = 8'h6E,
    parameter logic [7:0] CMD_DUMP  = 8'h64,
    parameter int         AUTO_DUMP = 1,
    parameter int         CNT_W     = 32
) (
    input  logic         clk,
    input  logic         reset,
    debug_step_if.slave  bus
);

    typedef enum logic [2:0] {
        S_HALT,
        S_ARG,
        S_RUN,
        S_STEP,
        S_DUMP_WAIT
    } state_t;

    localparam state_t S_AFTER_STOP = (AUTO_DUMP != 0) ? S_DUMP_WAIT : S_HALT;

    state_t           state_q, state_d;
    logic [8:0]       step_rem_q, step_rem_d;
    logic             cmd_error_q, cmd_error_d;
    logic             dump_start_q, dump_start_d;
    logic [CNT_W-1:0] cycle_count_q;
    logic             pipe_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_HALT;
            step_rem_q    <= 9'd0;
            cmd_error_q   <= 1'b0;
            dump_start_q  <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            step_rem_q    <= step_rem_d;
            cmd_error_q   <= cmd_error_d;
            dump_start_q  <= dump_start_d;
            cycle_count_q <= cycle_count_q + CNT_W'(pipe_en);
        end
    end

    always_comb begin
        state_d     = state_q;
        step_rem_d  = step_rem_q;
        cmd_error_d = 1'b0;
        case (state_q)
            S_HALT: begin
                if (bus.rx_done_tick) begin
                    if (bus.rx_data == CMD_RUN) begin
                        state_d = S_RUN;
                    end else if (bus.rx_data == CMD_STEP) begin
                        state_d    = S_STEP;
                        step_rem_d = 9'd1;
                    end else if (bus.rx_data == CMD_STEPN) begin
                        state_d = S_ARG;
                    end else if (bus.rx_data == CMD_DUMP) begin
                        state_d = S_DUMP_WAIT;
                    end else if (bus.rx_data != CMD_HALT) begin
                        cmd_error_d = 1'b1;
                    end
                end
            end
            S_ARG: begin
                if (bus.rx_done_tick) begin
                    state_d    = S_STEP;
                    step_rem_d = (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
                end
            end
            S_RUN: begin
                if (bus.rx_done_tick) begin
                    if (bus.rx_data == CMD_HALT) begin
                        state_d = S_AFTER_STOP;
                    end else if (bus.rx_data == CMD_DUMP) begin
                        state_d = S_DUMP_WAIT;
                    end else if (bus.rx_data != CMD_RUN) begin
                        cmd_error_d = 1'b1;
                    end
                end
            end
            S_STEP: begin
                step_rem_d = step_rem_q - 9'd1;
                if (step_rem_q == 9'd1) begin
                    state_d = S_AFTER_STOP;
                end
                // A halt abort wins over completion and never triggers a dump.
                if (bus.rx_done_tick) begin
                    if (bus.rx_data == CMD_HALT) begin
                        state_d    = S_HALT;
                        step_rem_d = 9'd0;
                    end else begin
                        cmd_error_d = 1'b1;
                    end
                end
            end
            S_DUMP_WAIT: begin
                if (bus.rx_done_tick) begin
                    cmd_error_d = 1'b1;
                end
                if (bus.dump_done && !dump_start_q) begin
                    state_d = S_HALT;
                end
            end
            default: begin
                state_d    = S_HALT;
                step_rem_d = 9'd0;
            end
        endcase
        dump_start_d = (state_d == S_DUMP_WAIT) && (state_q != S_DUMP_WAIT);
    end

    assign pipe_en = (state_q == S_RUN) || (state_q == S_STEP);

    always_comb begin
        bus.mode = 2'd0;
        case (state_q)
            S_RUN:       bus.mode = 2'd1;
            S_STEP:      bus.mode = 2'd2;
            S_DUMP_WAIT: bus.mode = 2'd3;
            default:     bus.mode = 2'd0;
        endcase
    end

    assign bus.pipe_en     = pipe_en;
    assign bus.dump_start  = dump_start_q;
    assign bus.cmd_error   = cmd_error_q;
    assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Bench for debug_step_ctrl: two instances (auto-dump with 32-bit counter,
// no auto-dump with 8-bit counter) run side by side against a reference model.
module tb_debug_step_ctrl;

    localparam int M_HALT = 0, M_ARG = 1, M_RUN = 2, M_STEP = 3, M_DUMP = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    debug_step_if #(.CNT_W(32)) ifa ();
    debug_step_if #(.CNT_W(8))  ifb ();

    debug_step_ctrl #(.AUTO_DUMP(1), .CNT_W(32)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    debug_step_ctrl #(.AUTO_DUMP(0), .CNT_W(8))  dut_b (.clk(clk), .reset(reset), .bus(ifb));

    int checks = 0;
    int errors = 0;

    int          m_st  [2];
    int          m_rem [2];
    logic [63:0] m_cnt [2];
    bit          m_ds  [2];
    bit          m_er  [2];
    int          en_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_mode(input int k);
        case (m_st[k])
            M_RUN:   return 2'd1;
            M_STEP:  return 2'd2;
            M_DUMP:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic bit exp_pe(input int k);
        return (m_st[k] == M_RUN) || (m_st[k] == M_STEP);
    endfunction

    // Reference: applies one clock edge of the command rules to model k.
    task automatic model_edge(input int k, input logic [7:0] b, input bit t, input bit d, input bit r);
        int  nst;
        int  nrem;
        bit  err;
        bit  autod;
        logic [63:0] mask;
        autod = (k == 0);
        mask  = (k == 0) ? 64'hFFFF_FFFF : 64'hFF;
        if (r) begin
            m_st[k] = M_HALT; m_rem[k] = 0; m_cnt[k] = 0; m_ds[k] = 0; m_er[k] = 0;
            return;
        end
        nst = m_st[k]; nrem = m_rem[k]; err = 0;
        case (m_st[k])
            M_HALT: if (t) begin
                if (b == "c") nst = M_RUN;
                else if (b == "s") begin nst = M_STEP; nrem = 1; end
                else if (b == "n") nst = M_ARG;
                else if (b == "d") nst = M_DUMP;
                else if (b != "h") err = 1;
            end
            M_ARG: if (t) begin
                nst  = M_STEP;
                nrem = (b == 0) ? 256 : int'(b);
            end
            M_RUN: if (t) begin
                if (b == "h") nst = autod ? M_DUMP : M_HALT;
                else if (b == "d") nst = M_DUMP;
                else if (b != "c") err = 1;
            end
            M_STEP: begin
                nrem = m_rem[k] - 1;
                if (m_rem[k] == 1) nst = autod ? M_DUMP : M_HALT;
                if (t) begin
                    if (b == "h") nst = M_HALT;
                    else err = 1;
                end
            end
            default: begin
                if (t) err = 1;
                if (d && !m_ds[k]) nst = M_HALT;
            end
        endcase
        if (exp_pe(k)) m_cnt[k] = (m_cnt[k] + 1) & mask;
        m_ds[k]  = (nst == M_DUMP) && (m_st[k] != M_DUMP);
        m_er[k]  = err;
        m_st[k]  = nst;
        m_rem[k] = nrem;
    endtask

    task automatic cyc(input logic [7:0] b, input bit t, input bit d, input bit r);
        ifa.rx_data = b; ifa.rx_done_tick = t; ifa.dump_done = d;
        ifb.rx_data = b; ifb.rx_done_tick = t; ifb.dump_done = d;
        reset = r;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k, b, t, d, r);
        #1;
        chk("pipe_en_a",     64'(ifa.pipe_en),     64'(exp_pe(0)));
        chk("dump_start_a",  64'(ifa.dump_start),  64'(m_ds[0]));
        chk("mode_a",        64'(ifa.mode),        64'(exp_mode(0)));
        chk("cmd_error_a",   64'(ifa.cmd_error),   64'(m_er[0]));
        chk("cycle_count_a", 64'(ifa.cycle_count), m_cnt[0]);
        chk("pipe_en_b",     64'(ifb.pipe_en),     64'(exp_pe(1)));
        chk("dump_start_b",  64'(ifb.dump_start),  64'(m_ds[1]));
        chk("mode_b",        64'(ifb.mode),        64'(exp_mode(1)));
        chk("cmd_error_b",   64'(ifb.cmd_error),   64'(m_er[1]));
        chk("cycle_count_b", 64'(ifb.cycle_count), m_cnt[1]);
        if (ifa.pipe_en === 1'b1) en_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(8'h00, 0, 0, 0);
    endtask

    task automatic send(input logic [7:0] b);
        cyc(b, 1, 0, 0);
    endtask

    task automatic do_reset();
        cyc(8'h00, 0, 0, 1);
        cyc(8'h00, 0, 0, 1);
    endtask

    initial begin
        logic [7:0] b;
        bit t, d, r;
        int sel;
        for (int k = 0; k < 2; k++) begin
            m_st[k] = M_HALT; m_rem[k] = 0; m_cnt[k] = 0; m_ds[k] = 0; m_er[k] = 0;
        end
        en_seen = 0;

        // reset state, with a byte strobed during reset
        cyc("c", 1, 0, 1);
        do_reset();
        chk("reset_mode", 64'(ifa.mode), 64'd0);
        chk("reset_count", 64'(ifa.cycle_count), 64'd0);

        // free run for 100 cycles, then halt
        send("c");
        chk("run_pe_next", 64'(ifb.pipe_en), 64'd1);
        idle(99);
        send("h");
        chk("halt_pe", 64'(ifb.pipe_en), 64'd0);
        chk("run100_count", 64'(ifb.cycle_count), 64'd100);
        chk("halt_autodump_a", 64'(ifa.dump_start), 64'd1);

        // single step with auto-dump
        do_reset();
        send("s");
        chk("step_pe", 64'(ifa.pipe_en), 64'd1);
        idle(1);
        chk("step_pe_off", 64'(ifa.pipe_en), 64'd0);
        chk("step_dump_start", 64'(ifa.dump_start), 64'd1);
        chk("step_mode3", 64'(ifa.mode), 64'd3);
        cyc(8'h00, 0, 1, 0);
        chk("dump_done_ignored_first", 64'(ifa.mode), 64'd3);
        cyc(8'h00, 0, 1, 0);
        chk("dump_done_mode0", 64'(ifa.mode), 64'd0);

        // N-step: 5 then 256
        do_reset();
        en_seen = 0;
        send("n"); send(8'h05); idle(8);
        chk("nstep5_cycles", 64'(en_seen), 64'd5);
        cyc(8'h00, 0, 1, 0);
        en_seen = 0;
        send("n"); send(8'h00); idle(260);
        chk("nstep256_cycles", 64'(en_seen), 64'd256);
        cyc(8'h00, 0, 1, 0);
        chk("nstep_total_a", 64'(ifa.cycle_count), 64'd261);
        chk("nstep_total_b", 64'(ifb.cycle_count), 64'd5);

        // halt abort on the 10th step cycle
        do_reset();
        send("n"); send(8'hFF); idle(9); send("h");
        chk("abort_pe", 64'(ifa.pipe_en), 64'd0);
        chk("abort_no_dump", 64'(ifa.dump_start), 64'd0);
        chk("abort_count", 64'(ifa.cycle_count), 64'd10);
        idle(2);
        chk("abort_mode", 64'(ifa.mode), 64'd0);

        // error cases
        do_reset();
        send("x");
        chk("err_halt", 64'(ifa.cmd_error), 64'd1);
        idle(1);
        chk("err_pulse_width", 64'(ifa.cmd_error), 64'd0);
        send("c"); send("s");
        chk("err_run", 64'(ifa.cmd_error), 64'd1);
        chk("err_run_mode", 64'(ifa.mode), 64'd1);
        send("d"); idle(1); send("q");
        chk("err_dump", 64'(ifb.cmd_error), 64'd1);
        cyc(8'h00, 0, 1, 0);
        cyc(8'h00, 0, 1, 0);
        chk("dump_done_halt_mode", 64'(ifa.mode), 64'd0);

        // reset mid N-step and in dump wait
        send("n"); send(8'd50); idle(5);
        cyc(8'h00, 0, 0, 1);
        chk("rst_step_pe", 64'(ifa.pipe_en), 64'd0);
        chk("rst_step_count", 64'(ifa.cycle_count), 64'd0);
        cyc("d", 1, 0, 0);
        cyc(8'h00, 0, 1, 1);
        chk("rst_dump_mode", 64'(ifa.mode), 64'd0);
        chk("rst_dump_start", 64'(ifa.dump_start), 64'd0);

        // counter wrap on the 8-bit instance
        send("c"); idle(250);
        chk("wrap_pre", 64'(ifb.cycle_count), 64'd250);
        idle(10);
        chk("wrap_post", 64'(ifb.cycle_count), 64'd4);
        chk("nowrap_a", 64'(ifa.cycle_count), 64'd260);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 7));
            case (sel)
                0: b = "c";
                1: b = "h";
                2: b = "s";
                3: b = "n";
                4: b = "d";
                default: b = 8'($urandom_range(0, 255));
            endcase
            t = ($urandom_range(0, 4) == 0);
            d = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 399) == 0);
            cyc(b, t, d, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
